// File: rtl/csa_tree_pkg.sv
// Shared definitions for the CSA adder tree, its frame loader and benches.
package csa_tree_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    WAIT   = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Number of 3:2 carry-save reduction stages needed to bring n operands
  // down to the final three feeding the carry-propagate adder.
  function automatic int StageCount(input int n);
    int k;
    int s;
    k = n;
    s = 0;
    while (k > 3) begin
      k = k - (k / 3);
      s = s + 1;
    end
    return s;
  endfunction

  // Sum width wide enough for n words of w bits each.
  function automatic int OutWidth(input int w, input int n);
    return w + StageCount(n) + 2;
  endfunction

endpackage

// File: rtl/csa_tree_frame_loader.sv
// Packs a serial word stream into a parallel frame for the CSA tree, waits a
// fixed latency for the tree, then presents the captured sum with backpressure.
module csa_tree_frame_loader
  import csa_tree_pkg::*;
#(
  parameter int I_DATA_W = 3,
  parameter int I_DATA_N = 16,
  parameter int TREE_LAT = 6,
  parameter int O_DATA_W = OutWidth(I_DATA_W, I_DATA_N)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [I_DATA_W-1:0]                  s_data,
  input  logic                                 s_last,
  output logic [0:I_DATA_N-1][I_DATA_W-1:0]    tree_data,
  input  logic [O_DATA_W-1:0]                  tree_sum,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [O_DATA_W-1:0]                  m_data,
  output logic                                 frame_err
);

  localparam int IDX_W = $clog2(I_DATA_N);
  localparam int LAT_W = $clog2(TREE_LAT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(I_DATA_N - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TREE_LAT - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [LAT_W-1:0]   lat_cnt;
  logic               accept;
  logic               last_slot;

  assign s_ready   = (state == FILL);
  assign accept    = s_valid && s_ready;
  assign last_slot = (idx == IDX_LAST);

  // Frame FSM: fill slots, wait out the tree latency, hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      idx     <= '0;
      lat_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (last_slot) begin
              idx     <= '0;
              lat_cnt <= '0;
              state   <= WAIT;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        WAIT: begin
          // lat_cnt holds k-1 at edge E0+k, so capture lands on E0+TREE_LAT.
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (lat_cnt == LAT_LAST) begin
            m_data  <= tree_sum;
            m_valid <= 1'b1;
            state   <= RESULT;
          end
        end
        RESULT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Frame register: accepted words land in their slot; unwritten slots keep
  // the previous frame's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tree_data <= '0;
    end else if (accept) begin
      tree_data[idx] <= s_data;
    end
  end

  // Sticky framing check: s_last must mark exactly the final slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (accept && (s_last != last_slot)) begin
      frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csa_tree_frame_loader.sv
// Randomized bench for csa_tree_frame_loader with a pipelined stand-in for
// the adder tree and a frame-level reference model.
module tb_csa_tree_frame_loader;
  import csa_tree_pkg::*;

  localparam int W  = 3;
  localparam int N  = 16;
  localparam int TL = 6;
  localparam int OW = OutWidth(W, N);

  logic clk = 1'b0;
  logic rst, s_valid, s_ready, s_last, m_valid, m_ready, frame_err;
  logic [W-1:0]            s_data;
  logic [0:N-1][W-1:0]     tree_data;
  logic [OW-1:0]           tree_sum, m_data;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  csa_tree_frame_loader #(
    .I_DATA_W(W),
    .I_DATA_N(N),
    .TREE_LAT(TL),
    .O_DATA_W(OW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .tree_data(tree_data), .tree_sum(tree_sum),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .frame_err(frame_err)
  );

  // Tree stand-in: sum of all slots, delayed through TL-1 register stages.
  logic [OW-1:0] comb_sum;
  logic [OW-1:0] pipe [0:TL-2];
  always_comb begin
    comb_sum = '0;
    for (int i = 0; i < N; i++) comb_sum = comb_sum + OW'(tree_data[i]);
  end
  always @(posedge clk) begin
    pipe[0] <= comb_sum;
    for (int k = 1; k < TL - 1; k++) pipe[k] <= pipe[k-1];
  end
  assign tree_sum = pipe[TL-2];

  // Reference model: accepted-word count, latency countdown, pending result.
  bit started = 0;
  int md_cnt  = 0;
  int md_left = 0;
  bit md_wait = 0;
  bit md_pend = 0;
  bit md_err  = 0;
  int md_sum  = 0;
  int md_slot [N];

  function automatic bit md_fill();
    return !md_wait && !md_pend;
  endfunction

  task automatic model_step();
    if (rst) begin
      started = 1;
      md_cnt = 0; md_left = 0; md_wait = 0; md_pend = 0; md_err = 0; md_sum = 0;
      for (int i = 0; i < N; i++) md_slot[i] = 0;
    end else if (!started) begin
      // nothing known before the first reset
    end else if (md_fill()) begin
      if (s_valid) begin
        md_slot[md_cnt] = int'(s_data);
        if (s_last != (md_cnt == N - 1)) md_err = 1;
        md_cnt++;
        if (md_cnt == N) begin
          md_cnt  = 0;
          md_wait = 1;
          md_left = TL;
        end
      end
    end else if (md_wait) begin
      md_left--;
      if (md_left == 0) begin
        md_wait = 0;
        md_pend = 1;
        md_sum  = 0;
        for (int i = 0; i < N; i++) md_sum += md_slot[i];
      end
    end else if (md_pend && m_ready) begin
      md_pend = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("s_ready",   int'(s_ready),   int'(md_fill()));
      check("m_valid",   int'(m_valid),   int'(md_pend));
      check("m_data",    int'(m_data),    md_sum);
      check("frame_err", int'(frame_err), int'(md_err));
      for (int i = 0; i < N; i++) check($sformatf("tree_data[%0d]", i), int'(tree_data[i]), md_slot[i]);
    end
  end

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int d, input bit l);
    bit r;
    int b;
    b = 0;
    s_valid = 1'b1;
    s_data  = W'(d);
    s_last  = l;
    forever begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk); #1;
      if (r) break;
      b++;
      if (b > 200) begin
        compared++; mismatched++;
        $display("FAIL push_timeout: s_ready stuck low for %0d cycles", b);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic frame(input int words [N], input int last_pos, input bit gaps, output int sum);
    sum = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      push(words[i], (i == last_pos));
      sum += words[i];
    end
  endtask

  task automatic wait_result(input string name, input int exp);
    int b;
    b = 0;
    forever begin
      @(negedge clk);
      if (m_valid) break;
      b++;
      if (b > 100) break;
    end
    if (!m_valid) begin
      compared++; mismatched++;
      $display("FAIL %s_timeout: m_valid never rose, expected sum %0d", name, exp);
    end else begin
      check(name, int'(m_data), exp);
      check({name, "_model"}, md_sum, exp);
    end
    @(posedge clk); #1;
  endtask

  int words [N];
  int sum;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready",   int'(s_ready),   1);
    check("rst_m_valid",   int'(m_valid),   0);
    check("rst_m_data",    int'(m_data),    0);
    check("rst_frame_err", int'(frame_err), 0);
    @(posedge clk); #1;

    // 1: all sevens
    for (int i = 0; i < N; i++) words[i] = 7;
    frame(words, N - 1, 0, sum);
    wait_result("t1_sum", 112);
    check("t1_frame_err", int'(frame_err), 0);

    // 2: ramp 0..7 twice
    for (int i = 0; i < N; i++) words[i] = i % 8;
    frame(words, N - 1, 0, sum);
    wait_result("t2_sum", 56);

    // 3: backpressure on the result, sender pushing meanwhile
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) words[i] = 1;
    frame(words, N - 1, 0, sum);
    wait_result("t3_sum", 16);
    s_valid = 1'b1; s_data = 3'd5; s_last = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("t3_hold", int'(m_data), 16);
    check("t3_hold_valid", int'(m_valid), 1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;

    // 4: random words with random valid gaps
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) words[i] = int'($urandom_range(0, 7));
      frame(words, N - 1, 1, sum);
      wait_result($sformatf("t4_sum%0d", f), sum);
    end

    // 5: early s_last, then a clean frame
    for (int i = 0; i < N; i++) words[i] = int'($urandom_range(0, 7));
    frame(words, 5, 0, sum);
    wait_result("t5_sum", sum);
    check("t5_err_set", int'(frame_err), 1);
    for (int i = 0; i < N; i++) words[i] = 3;
    frame(words, N - 1, 1, sum);
    wait_result("t5_clean_sum", 48);
    check("t5_err_sticky", int'(frame_err), 1);

    // 6: abort mid-frame with reset, then a full frame of twos
    for (int i = 0; i < 9; i++) push(1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(TL + 4);
    for (int i = 0; i < N; i++) words[i] = 2;
    frame(words, N - 1, 0, sum);
    wait_result("t6_sum", 32);
    check("t6_frame_err", int'(frame_err), 0);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/csa_tree_frame_loader.md
Name: csa_tree_frame_loader

Overview:
Front/back-end wrapper for the CSA adder tree.
- Packs a serial valid/ready stream of I_DATA_W-bit words into one I_DATA_N-word parallel frame and drives the tree's i_data.
- Holds the frame stable while the tree computes, then captures the tree's o_data after a fixed latency.
- Presents the sum on a valid/ready output with backpressure. One frame in flight at a time.

Parameters:
I_DATA_W, 3, width of each input word
I_DATA_N, 16, words per frame (tree input count, ≥ 3)
TREE_LAT, 6, clock edges from a stable tree input to a valid tree output
O_DATA_W, csa_tree_pkg::OutWidth(I_DATA_W, I_DATA_N), sum width (10 for the defaults)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
s_valid  input  1  input word valid
s_ready  output  1  loader accepts a word
s_data  input  I_DATA_W  input word
s_last  input  1  sender's end-of-frame marker, used for checking only
tree_data  output  [0:I_DATA_N-1][I_DATA_W-1:0]  packed frame to the tree's i_data; slot 0 = first word
tree_sum  input  O_DATA_W  tree's o_data
m_valid  output  1  sum valid
m_ready  input  1  consumer accepts the sum
m_data  output  O_DATA_W  captured sum
frame_err  output  1  sticky framing error

Behaviour:
- Reset, synchronous and active-high:
  - state=FILL, idx=0, lat_cnt=0.
  - tree_data=0, m_valid=0, m_data=0, frame_err=0.
  - s_ready is 1 in the first cycle after rst deasserts.
  - Asserting rst mid-frame or with a pending result discards everything. No output is produced for the discarded frame.
- FILL state:
  - s_ready=1, m_valid=0.
  - On s_valid&&s_ready, s_data is written into tree_data[idx] and idx increments.
  - On acceptance at idx==I_DATA_N-1: idx←0, lat_cnt←0, go to WAIT.
  - Slots not yet written in the current frame keep their previous-frame values. The tree output is not sampled until the frame is complete.
- WAIT state:
  - s_ready=0. tree_data is frozen.
  - lat_cnt increments every edge.
  - Let E0 be the edge that accepted the last word. At edge E0+TREE_LAT: m_data←tree_sum, m_valid←1, go to RESULT.
- RESULT state:
  - s_ready=0. m_valid=1. m_data is held stable until the handshake.
  - On m_valid&&m_ready: m_valid←0, go to FILL. s_ready rises the cycle after.
  - m_ready asserted while m_valid=0 has no effect.
- Throughput: at most one frame per I_DATA_N+TREE_LAT+1 cycles when there are no stalls.
- s_last check, only on accepted words:
  - s_last=1 at idx≠I_DATA_N-1 sets frame_err.
  - s_last=0 at idx==I_DATA_N-1 sets frame_err.
  - s_last never changes frame length; frames are always exactly I_DATA_N words.
  - frame_err is cleared only by rst.
- s_valid while s_ready=0 is ignored; the sender must hold its word.
- Arithmetic is done entirely by the tree. The loader only registers values; no truncation, since O_DATA_W covers I_DATA_N·(2^I_DATA_W−1).
- TREE_LAT=1 is legal: capture happens at E0+1.
- lat_cnt width is $clog2(TREE_LAT+1).
- idx width is $clog2(I_DATA_N).

Decomposition:
- csa_tree_pkg (shared with the tree and benches) contains:
  - StageCount(n): the CSA reduction-stage count function. StageCount(16)=5.
  - OutWidth(w,n) = w + StageCount(n) + 2.
  - state enum typedef {FILL, WAIT, RESULT}.
- No sub-module: a single FSM with two counters. The tree is instantiated next to the loader by the parent, not inside it.

Test Plan (defaults; the bench connects the real 16-input tree to tree_data/tree_sum, m_ready=1 unless stated):
1. All 16 words = 7, s_last on word 16 -> m_valid rises exactly 6 edges after the 16th accept; m_data=112; frame_err=0.
2. Words 0,1,...,7,0,...,7 -> m_data=56; s_ready=0 from the edge after the 16th accept until the edge after the m handshake.
3. Backpressure: frame of all 1s, m_ready=0 for 10 cycles after m_valid -> m_data=16 held stable; s_valid held high is not accepted; then m_ready=1 gives one handshake, and the next frame's word 0 lands in slot 0.
4. s_valid toggling randomly across a frame of $random words -> m_data equals the software sum of the accepted words; no word is dropped or duplicated.
5. s_last asserted on word 5 of a frame -> frame_err=1 and stays 1 through later clean frames; the frame still completes at 16 words with the correct sum.
6. rst pulsed after 9 words, then a full frame of 2s -> no m_valid for the aborted frame; frame_err=0; m_data=32.
